// File: rtl/gate_stimulus_checker_pkg.sv
// Shared types and constants for the logic_gates stimulus/response checker.
// Holds state encodings, vector count, fail-mask bit positions and error ceiling.
package gate_stimulus_checker_pkg;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = $clog2(NUM_VECTORS);
    localparam int NUM_GATES   = 7;

    // Fail-mask / expected-vector bit positions
    localparam int BIT_AND  = 0;
    localparam int BIT_OR   = 1;
    localparam int BIT_NOT  = 2;
    localparam int BIT_NAND = 3;
    localparam int BIT_NOR  = 4;
    localparam int BIT_XOR  = 5;
    localparam int BIT_XNOR = 6;

    localparam logic [3:0] ERR_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [NUM_GATES-1:0] gate_vec_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == ERR_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/gate_stimulus_checker_if.sv
// Bundle between the checker, the logic_gates block and the run controller.
// master: checker side (drives a/b and status, receives start and gate outputs).
interface gate_stimulus_checker_if;

    logic       start;
    logic       a;
    logic       b;
    logic       and_y;
    logic       or_y;
    logic       not_y;
    logic       nand_y;
    logic       nor_y;
    logic       xor_y;
    logic       xnor_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [6:0] fail_mask;

    modport master (
        input  start,
        input  and_y, or_y, not_y, nand_y, nor_y, xor_y, xnor_y,
        output a, b,
        output busy, done, pass, err_count, fail_mask
    );

    modport slave (
        output start,
        output and_y, or_y, not_y, nand_y, nor_y, xor_y, xnor_y,
        input  a, b,
        input  busy, done, pass, err_count, fail_mask
    );

endinterface

// File: rtl/gate_stimulus_checker_ref_model.sv
// Combinational reference for the seven logic_gates outputs.
// Ports: a, b in; exp out, 7 bits in fail-mask order (and..xnor = bit0..bit6).
module gate_ref_model
    import gate_stimulus_checker_pkg::*;
(
    input  logic      a,
    input  logic      b,
    output gate_vec_t exp
);

    always_comb begin
        exp           = '0;
        exp[BIT_AND]  = a & b;
        exp[BIT_OR]   = a | b;
        exp[BIT_NOT]  = ~a;
        exp[BIT_NAND] = ~(a & b);
        exp[BIT_NOR]  = ~(a | b);
        exp[BIT_XOR]  = a ^ b;
        exp[BIT_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_stimulus_checker.sv
// Self-running stimulus and response checker for logic_gates: walks {a,b}
// through 00..11, holds each HOLD_CYCLES, compares on the last hold cycle.
// Ports: clk, rst (async, active high); bus (master): start in, gate outputs
// in, a/b out, busy/done/pass/err_count/fail_mask out.
module gate_stimulus_checker
    import gate_stimulus_checker_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int LOOPS       = 1
) (
    input logic clk,
    input logic rst,
    gate_stimulus_checker_if.master bus
);

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0]       LOOP_LAST = 4'(LOOPS - 1);
    localparam logic [VEC_W-1:0] VEC_LAST  = VEC_W'(NUM_VECTORS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       hold_q;
    logic [VEC_W-1:0] vec_q;
    logic [3:0]       loop_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       err_q;
    gate_vec_t        mask_q;

    logic             accept;
    logic             sample;
    logic             last_sample;

    gate_vec_t        exp_vec;
    gate_vec_t        dut_vec;
    gate_vec_t        mism;

    // {a,b} is the vector index itself, so a/b come straight from flops
    gate_ref_model u_ref (
        .a   (vec_q[1]),
        .b   (vec_q[0]),
        .exp (exp_vec)
    );

    always_comb begin
        dut_vec           = '0;
        dut_vec[BIT_AND]  = bus.and_y;
        dut_vec[BIT_OR]   = bus.or_y;
        dut_vec[BIT_NOT]  = bus.not_y;
        dut_vec[BIT_NAND] = bus.nand_y;
        dut_vec[BIT_NOR]  = bus.nor_y;
        dut_vec[BIT_XOR]  = bus.xor_y;
        dut_vec[BIT_XNOR] = bus.xnor_y;
    end

    assign mism = dut_vec ^ exp_vec;

    // State register; busy/done are registered from the next state
    // so they never glitch on the two-bit state change DRIVE->DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == DRIVE);
            done_q  <= (state_d == DONE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = DRIVE;
            DRIVE:   if (last_sample) state_d = DONE;
            DONE:    if (bus.start) state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        accept      = 1'b0;
        sample      = 1'b0;
        last_sample = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                accept = bus.start;
            end
            DRIVE: begin
                sample      = (hold_q == HOLD_LAST);
                last_sample = sample
                            && (vec_q == VEC_LAST)
                            && (loop_q == LOOP_LAST);
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    // Counters and sticky result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            vec_q  <= '0;
            loop_q <= '0;
            err_q  <= '0;
            mask_q <= '0;
        end else if (accept) begin
            hold_q <= '0;
            vec_q  <= '0;
            loop_q <= '0;
            err_q  <= '0;
            mask_q <= '0;
        end else if (sample) begin
            // Index wrap after the final sample leaves {a,b}=00
            hold_q <= '0;
            vec_q  <= vec_q + 1'b1;
            if (vec_q == VEC_LAST) begin
                loop_q <= last_sample ? 4'd0 : loop_q + 4'd1;
            end
            if (|mism) begin
                err_q  <= sat_inc(err_q);
                mask_q <= mask_q | mism;
            end
        end else if (state_q == DRIVE) begin
            hold_q <= hold_q + 8'd1;
        end
    end

    assign bus.a         = vec_q[1];
    assign bus.b         = vec_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_count = err_q;
    assign bus.fail_mask = mask_q;
    assign bus.pass      = done_q && (err_q == 4'd0);

endmodule

// File: tb/tb_gate_stimulus_checker.sv
// Directed bench for gate_stimulus_checker: four instances with different
// HOLD_CYCLES/LOOPS and clean, stuck-xor or fully inverted gate models.
module tb_gate_stimulus_checker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gate_stimulus_checker_if bus0 ();
    gate_stimulus_checker_if bus1 ();
    gate_stimulus_checker_if bus2 ();
    gate_stimulus_checker_if bus3 ();

    gate_stimulus_checker #(.HOLD_CYCLES(10), .LOOPS(1)) u0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    gate_stimulus_checker #(.HOLD_CYCLES(3), .LOOPS(2)) u1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    gate_stimulus_checker #(.HOLD_CYCLES(1), .LOOPS(5)) u2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );
    gate_stimulus_checker #(.HOLD_CYCLES(1), .LOOPS(1)) u3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );

    // Bench-side logic_gates: {xnor,xor,nor,nand,not,or,and}
    function automatic logic [6:0] gates(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    assign {bus0.xnor_y, bus0.xor_y, bus0.nor_y, bus0.nand_y,
            bus0.not_y, bus0.or_y, bus0.and_y} = gates(bus0.a, bus0.b);
    // xor stuck at 0
    assign {bus1.xnor_y, bus1.xor_y, bus1.nor_y, bus1.nand_y,
            bus1.not_y, bus1.or_y, bus1.and_y} =
            gates(bus1.a, bus1.b) & 7'b1011111;
    // every output inverted
    assign {bus2.xnor_y, bus2.xor_y, bus2.nor_y, bus2.nand_y,
            bus2.not_y, bus2.or_y, bus2.and_y} = ~gates(bus2.a, bus2.b);
    assign {bus3.xnor_y, bus3.xor_y, bus3.nor_y, bus3.nand_y,
            bus3.not_y, bus3.or_y, bus3.and_y} = gates(bus3.a, bus3.b);

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] err;
        logic [6:0] mask;
    } obs_t;

    typedef struct {
        int   k;
        logic a;
        logic b;
        logic busy;
        logic done;
        logic pass;
    } vec_t;

    int passed = 0;
    int total  = 0;

    function automatic obs_t get(input int id);
        case (id)
            0: get = {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass,
                      bus0.err_count, bus0.fail_mask};
            1: get = {bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass,
                      bus1.err_count, bus1.fail_mask};
            2: get = {bus2.a, bus2.b, bus2.busy, bus2.done, bus2.pass,
                      bus2.err_count, bus2.fail_mask};
            default: get = {bus3.a, bus3.b, bus3.busy, bus3.done, bus3.pass,
                            bus3.err_count, bus3.fail_mask};
        endcase
    endfunction

    task automatic set_start(input int id, input logic v);
        case (id)
            0: bus0.start = v;
            1: bus1.start = v;
            2: bus2.start = v;
            default: bus3.start = v;
        endcase
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Returns just after the negedge following the accepting edge (k=0)
    task automatic pulse_start(input int id);
        @(negedge clk);
        set_start(id, 1'b1);
        @(negedge clk);
        set_start(id, 1'b0);
    endtask

    // Counts observed busy cycles from k=0; bounded
    task automatic count_busy(input int id, output int cycles);
        cycles = 0;
        while (get(id).busy && cycles < 2000) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    function automatic vec_t mk(input int k, input logic a, input logic b,
                                input logic busy, input logic done,
                                input logic pass);
        vec_t v;
        v.k = k; v.a = a; v.b = b;
        v.busy = busy; v.done = done; v.pass = pass;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        obs_t o;
        int   n;
        int   cur;

        tbl.push_back(mk(0,  0, 0, 1, 0, 0));
        tbl.push_back(mk(9,  0, 0, 1, 0, 0));
        tbl.push_back(mk(10, 0, 1, 1, 0, 0));
        tbl.push_back(mk(19, 0, 1, 1, 0, 0));
        tbl.push_back(mk(20, 1, 0, 1, 0, 0));
        tbl.push_back(mk(29, 1, 0, 1, 0, 0));
        tbl.push_back(mk(30, 1, 1, 1, 0, 0));
        tbl.push_back(mk(39, 1, 1, 1, 0, 0));
        tbl.push_back(mk(40, 0, 0, 0, 1, 1));

        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        bus3.start = 1'b0;
        rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        o = get(0);
        chk("rst_ab",   int'({o.a, o.b}), 0);
        chk("rst_busy", int'(o.busy), 0);
        chk("rst_done", int'(o.done), 0);
        chk("rst_pass", int'(o.pass), 0);
        chk("rst_err",  int'(o.err), 0);
        chk("rst_mask", int'(o.mask), 0);
        rst = 1'b0;

        // Default run, table-driven
        pulse_start(0);
        cur = 0;
        foreach (tbl[i]) begin
            while (cur < tbl[i].k) begin
                @(negedge clk);
                cur++;
            end
            o = get(0);
            chk($sformatf("run0_k%0d_ab", tbl[i].k),
                int'({o.a, o.b}), int'({tbl[i].a, tbl[i].b}));
            chk($sformatf("run0_k%0d_busy", tbl[i].k),
                int'(o.busy), int'(tbl[i].busy));
            chk($sformatf("run0_k%0d_done", tbl[i].k),
                int'(o.done), int'(tbl[i].done));
            chk($sformatf("run0_k%0d_pass", tbl[i].k),
                int'(o.pass), int'(tbl[i].pass));
        end
        o = get(0);
        chk("run0_err",  int'(o.err), 0);
        chk("run0_mask", int'(o.mask), 0);

        // Stuck xor, HOLD=3 LOOPS=2
        pulse_start(1);
        count_busy(1, n);
        o = get(1);
        chk("xor_busy_len", n, 24);
        chk("xor_done", int'(o.done), 1);
        chk("xor_err",  int'(o.err), 4);
        chk("xor_mask", int'(o.mask), 'h20);
        chk("xor_pass", int'(o.pass), 0);

        // Restart from DONE clears results within one edge
        pulse_start(1);
        o = get(1);
        chk("rerun_done", int'(o.done), 0);
        chk("rerun_err",  int'(o.err), 0);
        chk("rerun_mask", int'(o.mask), 0);
        chk("rerun_busy", int'(o.busy), 1);
        count_busy(1, n);
        o = get(1);
        chk("rerun_len", n, 24);
        chk("rerun_err_end", int'(o.err), 4);

        // Saturation: all inverted, HOLD=1 LOOPS=5
        pulse_start(2);
        count_busy(2, n);
        o = get(2);
        chk("sat_busy_len", n, 20);
        chk("sat_err",  int'(o.err), 15);
        chk("sat_mask", int'(o.mask), 'h7F);
        chk("sat_pass", int'(o.pass), 0);

        // HOLD=1: vector changes every edge
        pulse_start(3);
        for (int k = 0; k < 4; k++) begin
            o = get(3);
            chk($sformatf("h1_k%0d_ab", k), int'({o.a, o.b}), k);
            chk($sformatf("h1_k%0d_busy", k), int'(o.busy), 1);
            @(negedge clk);
        end
        o = get(3);
        chk("h1_busy_end", int'(o.busy), 0);
        chk("h1_done", int'(o.done), 1);
        chk("h1_pass", int'(o.pass), 1);

        // Start while busy is ignored
        pulse_start(0);
        repeat (5) @(negedge clk);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        count_busy(0, n);
        o = get(0);
        chk("sbusy_len", n + 6, 40);
        chk("sbusy_done", int'(o.done), 1);
        chk("sbusy_pass", int'(o.pass), 1);

        // Asynchronous reset mid-run (vector 01)
        pulse_start(0);
        repeat (17) @(negedge clk);
        o = get(0);
        chk("mid_ab_pre", int'({o.a, o.b}), 1);
        #1 rst = 1'b1;
        #1 o = get(0);
        chk("mid_ab",   int'({o.a, o.b}), 0);
        chk("mid_busy", int'(o.busy), 0);
        chk("mid_done", int'(o.done), 0);
        chk("mid_err",  int'(o.err), 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start(0);
        count_busy(0, n);
        o = get(0);
        chk("post_rst_len",  n, 40);
        chk("post_rst_pass", int'(o.pass), 1);
        chk("post_rst_ab",   int'({o.a, o.b}), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
